// File: rtl/acu_rs.sv
// ACU reservation station: holds ALU/compare ops until both operands arrive.
// Operands wake from the result broadcast bus, including a same-cycle allocation bypass.
module acu_rs #(
  parameter int size  = 8,
  parameter int TAG_W = 3
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush,
  input  logic                                  alloc_valid,
  output logic                                  alloc_ready,
  input  logic [3:0]                            alloc_op,
  input  logic                                  alloc_cmp,
  input  logic [TAG_W-1:0]                      alloc_rob_tag,
  input  logic                                  alloc_src1_valid,
  input  logic [31:0]                           alloc_src1_val,
  input  logic [TAG_W-1:0]                      alloc_src1_tag,
  input  logic                                  alloc_src2_valid,
  input  logic [31:0]                           alloc_src2_val,
  input  logic [TAG_W-1:0]                      alloc_src2_tag,
  input  logic                                  bcast_valid,
  input  logic [TAG_W-1:0]                      bcast_tag,
  input  logic [31:0]                           bcast_val,
  output logic [size-1:0]                       busy,
  output logic [size-1:0]                       ready,
  output logic [size-1:0][4+32+32+TAG_W-1:0]    data,
  output logic [size-1:0]                       acu_operation,
  input  logic [size-1:0]                       result_ack
);

  logic [size-1:0]             busy_q, busy_d;
  logic [size-1:0]             cmp_q, cmp_d;
  logic [size-1:0]             s1v_q, s1v_d;
  logic [size-1:0]             s2v_q, s2v_d;
  logic [size-1:0][3:0]        op_q, op_d;
  logic [size-1:0][31:0]       s1_q, s1_d;
  logic [size-1:0][31:0]       s2_q, s2_d;
  logic [size-1:0][TAG_W-1:0]  tag_q, tag_d;

  logic [size-1:0] sel;
  logic            found;
  logic            fire;
  logic            byp1, byp2;

  assign alloc_ready = ~&busy_q;
  assign fire        = alloc_valid & alloc_ready;
  assign busy        = busy_q;
  assign ready       = busy_q & s1v_q & s2v_q;
  assign acu_operation = cmp_q;

  assign byp1 = bcast_valid & (bcast_tag == alloc_src1_tag);
  assign byp2 = bcast_valid & (bcast_tag == alloc_src2_tag);

  always_comb begin
    for (int i = 0; i < size; i++) begin
      data[i] = {op_q[i], s1_q[i], s2_q[i], tag_q[i]};
    end
  end

  // Lowest-index free slot, from pre-edge busy state only.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < size; i++) begin
      if (!busy_q[i] && !found) begin
        sel[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    busy_d = busy_q;
    cmp_d  = cmp_q;
    s1v_d  = s1v_q;
    s2v_d  = s2v_q;
    op_d   = op_q;
    s1_d   = s1_q;
    s2_d   = s2_q;
    tag_d  = tag_q;
    for (int i = 0; i < size; i++) begin
      if (busy_q[i]) begin
        if (bcast_valid && !s1v_q[i] && bcast_tag == s1_q[i][TAG_W-1:0]) begin
          s1v_d[i] = 1'b1;
          s1_d[i]  = bcast_val;
        end
        if (bcast_valid && !s2v_q[i] && bcast_tag == s2_q[i][TAG_W-1:0]) begin
          s2v_d[i] = 1'b1;
          s2_d[i]  = bcast_val;
        end
        if (result_ack[i] && ready[i]) begin
          busy_d[i] = 1'b0;
        end
      end else if (fire && sel[i]) begin
        // A pending operand keeps its producer tag in the low value bits.
        busy_d[i] = 1'b1;
        cmp_d[i]  = alloc_cmp;
        op_d[i]   = alloc_op;
        tag_d[i]  = alloc_rob_tag;
        s1v_d[i]  = alloc_src1_valid | byp1;
        s2v_d[i]  = alloc_src2_valid | byp2;
        if (alloc_src1_valid) begin
          s1_d[i] = alloc_src1_val;
        end else if (byp1) begin
          s1_d[i] = bcast_val;
        end else begin
          s1_d[i] = 32'(alloc_src1_tag);
        end
        if (alloc_src2_valid) begin
          s2_d[i] = alloc_src2_val;
        end else if (byp2) begin
          s2_d[i] = bcast_val;
        end else begin
          s2_d[i] = 32'(alloc_src2_tag);
        end
      end
    end
    if (flush) begin
      busy_d = '0;
      s1v_d  = '0;
      s2v_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      cmp_q  <= '0;
      s1v_q  <= '0;
      s2v_q  <= '0;
      op_q   <= '0;
      s1_q   <= '0;
      s2_q   <= '0;
      tag_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cmp_q  <= cmp_d;
      s1v_q  <= s1v_d;
      s2v_q  <= s2v_d;
      op_q   <= op_d;
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      tag_q  <= tag_d;
    end
  end

endmodule

// File: tb/tb_acu_rs.sv
// Directed bench for acu_rs: alloc, wakeup, bypass, full, flush,
// multi-wake and reset priority with hand-computed expectations.
module tb_acu_rs;

  localparam int N  = 8;
  localparam int TW = 3;
  localparam int DW = 4 + 32 + 32 + TW;

  logic clk = 1'b0;
  logic rst, flush, alloc_valid, alloc_ready;
  logic [3:0] alloc_op;
  logic alloc_cmp;
  logic [TW-1:0] alloc_rob_tag;
  logic alloc_src1_valid, alloc_src2_valid;
  logic [31:0] alloc_src1_val, alloc_src2_val;
  logic [TW-1:0] alloc_src1_tag, alloc_src2_tag;
  logic bcast_valid;
  logic [TW-1:0] bcast_tag;
  logic [31:0] bcast_val;
  logic [N-1:0] busy, ready, acu_operation, result_ack;
  logic [N-1:0][DW-1:0] data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  acu_rs #(.size(N), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_op(alloc_op), .alloc_cmp(alloc_cmp),
    .alloc_rob_tag(alloc_rob_tag),
    .alloc_src1_valid(alloc_src1_valid),
    .alloc_src1_val(alloc_src1_val),
    .alloc_src1_tag(alloc_src1_tag),
    .alloc_src2_valid(alloc_src2_valid),
    .alloc_src2_val(alloc_src2_val),
    .alloc_src2_tag(alloc_src2_tag),
    .bcast_valid(bcast_valid), .bcast_tag(bcast_tag),
    .bcast_val(bcast_val),
    .busy(busy), .ready(ready), .data(data),
    .acu_operation(acu_operation), .result_ack(result_ack)
  );

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; flush = 0; alloc_valid = 0;
    alloc_op = 0; alloc_cmp = 0; alloc_rob_tag = 0;
    alloc_src1_valid = 0; alloc_src1_val = 0; alloc_src1_tag = 0;
    alloc_src2_valid = 0; alloc_src2_val = 0; alloc_src2_tag = 0;
    bcast_valid = 0; bcast_tag = 0; bcast_val = 0;
    result_ack = 0;
  endtask

  task automatic alloc(input logic [3:0] op, input logic cmp,
                       input logic [TW-1:0] rt,
                       input logic v1, input logic [31:0] s1,
                       input logic [TW-1:0] t1,
                       input logic v2, input logic [31:0] s2,
                       input logic [TW-1:0] t2);
    alloc_valid = 1; alloc_op = op; alloc_cmp = cmp;
    alloc_rob_tag = rt;
    alloc_src1_valid = v1; alloc_src1_val = s1; alloc_src1_tag = t1;
    alloc_src2_valid = v2; alloc_src2_val = s2; alloc_src2_tag = t2;
  endtask

  function automatic logic [31:0] f_s1(input logic [DW-1:0] d);
    return d[66:35];
  endfunction

  function automatic logic [31:0] f_s2(input logic [DW-1:0] d);
    return d[34:3];
  endfunction

  initial begin
    idle();
    rst = 1;
    step();
    step();
    rst = 0;
    chk("rst_busy", busy, 0);
    chk("rst_ready", ready, 0);
    chk("rst_aready", alloc_ready, 1);
    chk("rst_data", |data, 0);
    chk("rst_op", acu_operation, 0);

    // Basic alloc + ack
    alloc(4'h1, 0, 3'd2, 1, 32'd5, 0, 1, 32'd7, 0);
    step();
    idle();
    chk("add_busy", busy, 8'h01);
    chk("add_ready", ready, 8'h01);
    chk("add_data", data[0], {4'h1, 32'd5, 32'd7, 3'd2});
    result_ack = 8'h01;
    step();
    idle();
    chk("add_ack", busy, 8'h00);

    // Wakeup of src2 on tag 4, three cycles after alloc
    alloc(4'h2, 1, 3'd5, 1, 32'd3, 0, 0, 32'd0, 3'd4);
    step();
    idle();
    chk("wk_busy", busy, 8'h01);
    chk("wk_ready0", ready, 8'h00);
    chk("wk_cmp", acu_operation, 8'h01);
    bcast_valid = 1; bcast_tag = 3'd3; bcast_val = 32'hDEAD;
    step();
    idle();
    chk("wk_ready1", ready, 8'h00);
    step();
    chk("wk_ready2", ready, 8'h00);
    bcast_valid = 1; bcast_tag = 3'd4; bcast_val = 32'h1234;
    step();
    idle();
    chk("wk_ready3", ready, 8'h01);
    chk("wk_src2", f_s2(data[0]), 32'h1234);
    chk("wk_src1", f_s1(data[0]), 32'd3);
    result_ack = 8'h01;
    step();
    idle();

    // Same-cycle allocation bypass
    alloc(4'h3, 0, 3'd1, 0, 32'd0, 3'd6, 1, 32'd9, 0);
    bcast_valid = 1; bcast_tag = 3'd6; bcast_val = 32'hFF;
    step();
    idle();
    chk("byp_ready", ready, 8'h01);
    chk("byp_src1", f_s1(data[0]), 32'hFF);
    result_ack = 8'h01;
    step();
    idle();
    chk("byp_ack", busy, 8'h00);

    // Fill all entries
    for (int i = 0; i < N; i++) begin
      alloc(4'h4, 0, TW'(i), 1, 32'(16 + i), 0, 1, 32'd1, 0);
      step();
    end
    idle();
    chk("full_busy", busy, 8'hFF);
    chk("full_aready", alloc_ready, 0);
    alloc(4'h4, 0, 3'd0, 1, 32'h99, 0, 1, 32'd1, 0);
    step();
    chk("full_ign_busy", busy, 8'hFF);
    chk("full_ign_d0", f_s1(data[0]), 32'd16);
    // ack[3] while full: the concurrent alloc must be dropped
    alloc(4'h4, 0, 3'd0, 1, 32'hAA, 0, 1, 32'd1, 0);
    result_ack = 8'h08;
    step();
    result_ack = 0;
    chk("full_ack_busy", busy, 8'hF7);
    chk("full_ack_ar", alloc_ready, 1);
    alloc(4'h4, 0, 3'd0, 1, 32'hBB, 0, 1, 32'd1, 0);
    step();
    idle();
    chk("full_re_busy", busy, 8'hFF);
    chk("full_re_d3", f_s1(data[3]), 32'hBB);

    // Flush beats alloc and broadcast
    flush = 1;
    alloc(4'h5, 0, 3'd0, 1, 32'd1, 0, 1, 32'd1, 0);
    bcast_valid = 1; bcast_tag = 3'd1; bcast_val = 32'd7;
    result_ack = 8'h01;
    step();
    idle();
    chk("fl_busy", busy, 8'h00);
    chk("fl_ready", ready, 8'h00);
    chk("fl_aready", alloc_ready, 1);

    // Multi-wake: e0,e1,e3 wait on tag 1, e2 on tag 2
    alloc(4'h6, 0, 3'd0, 0, 32'd0, 3'd1, 1, 32'd10, 0);
    step();
    alloc(4'h6, 0, 3'd1, 1, 32'd11, 0, 0, 32'd0, 3'd1);
    step();
    alloc(4'h6, 0, 3'd2, 0, 32'd0, 3'd2, 1, 32'd12, 0);
    step();
    alloc(4'h6, 0, 3'd3, 0, 32'd0, 3'd1, 0, 32'd0, 3'd1);
    step();
    idle();
    chk("mw_busy", busy, 8'h0F);
    chk("mw_ready0", ready, 8'h00);
    result_ack = 8'h0F;
    step();
    idle();
    chk("mw_nack", busy, 8'h0F);
    bcast_valid = 1; bcast_tag = 3'd1; bcast_val = 32'h55;
    step();
    idle();
    chk("mw_ready", ready, 8'h0B);
    chk("mw_e3s1", f_s1(data[3]), 32'h55);
    chk("mw_e3s2", f_s2(data[3]), 32'h55);
    chk("mw_e0s2", f_s2(data[0]), 32'd10);

    // Same-cycle ack of e0 and alloc into e4
    result_ack = 8'h01;
    alloc(4'h7, 0, 3'd4, 1, 32'd1, 0, 1, 32'd2, 0);
    step();
    idle();
    chk("aa_busy", busy, 8'h1E);
    chk("aa_ready", ready, 8'h1A);
    alloc(4'h7, 1, 3'd5, 1, 32'd1, 0, 1, 32'd2, 0);
    step();
    idle();
    chk("pre_rst_busy", busy, 8'h1F);

    // Reset beats everything
    rst = 1;
    flush = 1;
    alloc(4'h8, 1, 3'd6, 1, 32'd3, 0, 1, 32'd4, 0);
    bcast_valid = 1; bcast_tag = 3'd2; bcast_val = 32'd9;
    result_ack = 8'hFF;
    step();
    idle();
    chk("rr_busy", busy, 8'h00);
    chk("rr_ready", ready, 8'h00);
    chk("rr_data", |data, 0);
    chk("rr_op", acu_operation, 8'h00);
    chk("rr_aready", alloc_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
